// File: rtl/reg_router_pkg.sv
// Shared types and default widths for the reg_write_router slice.
package reg_router_pkg;

  localparam int DEF_NUM_TARGETS    = 3;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Region bounds are stored zero-extended to this width, so ADDR_W may not exceed it.
  localparam int REGION_ADDR_W = 64;

  typedef struct packed {
    logic [REGION_ADDR_W-1:0] start_addr;
    logic [REGION_ADDR_W-1:0] end_addr;
    logic                     used;
  } region_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    DISPATCH = 2'd2,
    ERROR    = 2'd3
  } router_state_e;

  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_router_region_table.sv
// Region slot table: in-order slot allocation plus combinational
// lowest-index address match (hit flag and one-hot slot select).
module reg_router_region_table
  import reg_router_pkg::*;
#(
  parameter int NUM_TARGETS = DEF_NUM_TARGETS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SLOT_W      = slot_width(NUM_TARGETS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rg_valid,
  input  logic [ADDR_W-1:0]      i_rg_start,
  input  logic [ADDR_W-1:0]      i_rg_end,
  output logic                   o_rg_ready,
  output logic                   o_rg_done,
  output logic                   o_rg_err,
  output logic [SLOT_W-1:0]      o_rg_slot,
  input  logic [ADDR_W-1:0]      i_lookup_addr,
  output logic                   o_hit,
  output logic [NUM_TARGETS-1:0] o_hit_onehot
);

  localparam int PTR_W = $clog2(NUM_TARGETS + 1);

  if (ADDR_W > REGION_ADDR_W) begin : g_bad_addr_w
    $error("reg_router_region_table: ADDR_W exceeds REGION_ADDR_W");
  end

  region_t          r_slots [NUM_TARGETS];
  logic [PTR_W-1:0] r_ptr;
  logic             r_rg_done;
  logic             r_rg_err;
  logic [SLOT_W-1:0] r_rg_slot;

  logic                     w_full;
  logic                     w_accept;
  logic                     w_reject;
  logic [REGION_ADDR_W-1:0] w_lookup_ext;
  logic [NUM_TARGETS-1:0]   w_match;

  assign w_full   = (r_ptr == PTR_W'(NUM_TARGETS));
  assign w_accept = i_rg_valid && !w_full && (i_rg_start <= i_rg_end);
  assign w_reject = i_rg_valid && !w_accept;

  assign o_rg_ready = !rst && !w_full;
  assign o_rg_done  = r_rg_done;
  assign o_rg_err   = r_rg_err;
  assign o_rg_slot  = r_rg_slot;

  // NOTE: the slot array is reset because the used flags must read clear after
  // rst; a table without a valid bit per entry would not need it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        r_slots[i] <= '0;
      end
      r_ptr     <= '0;
      r_rg_done <= 1'b0;
      r_rg_err  <= 1'b0;
      r_rg_slot <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block
      // based on pre-edge values, independent of statement order.
      r_rg_done <= w_accept;
      r_rg_err  <= w_reject;
      if (w_accept) begin
        r_slots[r_ptr[SLOT_W-1:0]] <= '{
          start_addr: REGION_ADDR_W'(i_rg_start),
          end_addr:   REGION_ADDR_W'(i_rg_end),
          used:       1'b1
        };
        r_ptr     <= r_ptr + PTR_W'(1);
        r_rg_slot <= r_ptr[SLOT_W-1:0];
      end
    end
  end

  assign w_lookup_ext = REGION_ADDR_W'(i_lookup_addr);

  // NOTE: w_match is given a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      w_match[i] = r_slots[i].used
                   && (w_lookup_ext >= r_slots[i].start_addr)
                   && (w_lookup_ext <= r_slots[i].end_addr);
    end
  end

  // Isolating the lowest set bit gives lowest-index priority on overlap.
  assign o_hit_onehot = w_match & (~w_match + NUM_TARGETS'(1));
  assign o_hit        = |w_match;

endmodule

// File: rtl/reg_write_router.sv
// Routes single in-flight register writes to one of NUM_TARGETS address regions.
// Optional dispatch timeout is compiled in with `define ROUTER_TIMEOUT_EN.
module reg_write_router
  import reg_router_pkg::*;
#(
  parameter int  NUM_TARGETS    = DEF_NUM_TARGETS,
  parameter int  ADDR_W         = DEF_ADDR_W,
  parameter int  DATA_W         = DEF_DATA_W,
  parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int SLOT_W         = slot_width(NUM_TARGETS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rg_valid,
  input  logic [ADDR_W-1:0]      rg_start,
  input  logic [ADDR_W-1:0]      rg_end,
  output logic                   rg_ready,
  output logic                   rg_done,
  output logic                   rg_err,
  output logic [SLOT_W-1:0]      rg_slot,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [NUM_TARGETS-1:0] tgt_valid,
  input  logic [NUM_TARGETS-1:0] tgt_ready,
  output logic [ADDR_W-1:0]      tgt_addr,
  output logic [DATA_W-1:0]      tgt_data,
  output logic                   err_valid,
  output logic [ADDR_W-1:0]      err_addr
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("reg_write_router: TIMEOUT_CYCLES must be at least 1");
  end

  router_state_e          r_state;
  router_state_e          w_next_state;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_data;
  logic [NUM_TARGETS-1:0] r_sel;
  logic                   w_hit;
  logic [NUM_TARGETS-1:0] w_hit_onehot;
  logic                   w_tmo_hit;

  reg_router_region_table #(
    .NUM_TARGETS (NUM_TARGETS),
    .ADDR_W      (ADDR_W),
    .SLOT_W      (SLOT_W)
  ) u_table (
    .clk           (clk),
    .rst           (rst),
    .i_rg_valid    (rg_valid),
    .i_rg_start    (rg_start),
    .i_rg_end      (rg_end),
    .o_rg_ready    (rg_ready),
    .o_rg_done     (rg_done),
    .o_rg_err      (rg_err),
    .o_rg_slot     (rg_slot),
    .i_lookup_addr (r_addr),
    .o_hit         (w_hit),
    .o_hit_onehot  (w_hit_onehot)
  );

`ifdef ROUTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == DISPATCH) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    wr_ready     = 1'b0;
    tgt_valid    = '0;
    err_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        wr_ready = !rst;
        if (wr_valid) begin
          w_next_state = DECODE;
        end
      end
      DECODE: begin
        w_next_state = w_hit ? DISPATCH : ERROR;
      end
      DISPATCH: begin
        tgt_valid = r_sel;
        if (|(tgt_ready & r_sel)) begin
          w_next_state = IDLE;
        end else if (w_tmo_hit) begin
          w_next_state = ERROR;
        end
      end
      ERROR: begin
        err_valid    = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Captured write and chosen target stay frozen until the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_sel  <= '0;
    end else begin
      if ((r_state == IDLE) && wr_valid) begin
        r_addr <= wr_addr;
        r_data <= wr_data;
      end
      if (r_state == DECODE) begin
        r_sel <= w_hit_onehot;
      end
    end
  end

  assign tgt_addr = r_addr;
  assign tgt_data = r_data;
  assign err_addr = r_addr;

endmodule

// File: doc/reg_write_router.md
REG_WRITE_ROUTER -- requirements
Module: reg_write_router

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 3: number of region slots and target ports.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: write data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16: dispatch timeout limit; used only when ROUTER_TIMEOUT_EN is defined.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have ports rg_valid (input, 1), rg_start (input, ADDR_W), rg_end (input, ADDR_W), rg_ready (output, 1): region registration request.
REQ-008 SHALL have ports rg_done (output, 1) and rg_err (output, 1): one-cycle registration result pulses.
REQ-009 SHALL have ports rg_slot (output, $clog2(NUM_TARGETS)): slot index assigned, valid with rg_done.
REQ-010 SHALL have ports wr_valid (input, 1), wr_ready (output, 1), wr_addr (input, ADDR_W), wr_data (input, DATA_W): incoming write request.
REQ-011 SHALL have ports tgt_valid (output, NUM_TARGETS), tgt_ready (input, NUM_TARGETS), tgt_addr (output, ADDR_W), tgt_data (output, DATA_W): one-hot dispatch to targets.
REQ-012 SHALL have ports err_valid (output, 1) and err_addr (output, ADDR_W): unmapped or timed-out write report, one-cycle pulse.

Function
REQ-013 Registration SHALL assign slots in arrival order 0,1,2...; rg_ready=1 while a free slot exists.
REQ-014 rg_valid && rg_ready with rg_start<=rg_end SHALL store the region and pulse rg_done with rg_slot on the next cycle.
REQ-015 rg_start>rg_end, or rg_valid when the table is full, SHALL pulse rg_err next cycle and leave the table unchanged.
REQ-016 Regions SHALL be inclusive [start,end]; unsigned compare.
REQ-017 On overlap, the lowest-indexed matching slot SHALL win.
REQ-018 The FSM SHALL have states IDLE, DECODE, DISPATCH, ERROR.
REQ-019 IDLE: wr_ready=1; wr_valid captures addr and data, then goes to DECODE.
REQ-020 DECODE (one cycle): on a match go to DISPATCH, else go to ERROR; decode SHALL use the table contents as of that cycle, so a registration accepted in the same cycle is not visible.
REQ-021 DISPATCH: exactly one tgt_valid bit high; tgt_addr and tgt_data stable until tgt_ready on that bit; then go to IDLE.
REQ-022 ERROR: pulse err_valid with err_addr for one cycle, then go to IDLE.
REQ-023 wr_ready SHALL be 0 outside IDLE, so only one write is in flight at a time.
REQ-024 Minimum latency SHALL be: accept at cycle 0, tgt_valid at cycle 2, next accept at cycle 3 if tgt_ready is held high.
REQ-025 Registration and write handling SHALL proceed concurrently without mutual stall.

Reset
REQ-026 rst SHALL clear all slots, set FSM to IDLE, and set the slot pointer to 0.
REQ-027 Reset values SHALL be: wr_ready=0 while rst is high and 1 after; rg_ready=0 while rst is high and 1 after; tgt_valid=0; err_valid=0; rg_done=0; rg_err=0; all data outputs 0.
REQ-028 Reset mid-DISPATCH SHALL drop tgt_valid immediately; the in-flight write is discarded with no error reported.

Configuration
REQ-029 With ROUTER_TIMEOUT_EN defined: a DISPATCH counter SHALL start at 0; if it reaches TIMEOUT_CYCLES without tgt_ready, drop tgt_valid, pulse err_valid with err_addr, and go to IDLE.
REQ-030 Without ROUTER_TIMEOUT_EN: no counter SHALL exist and DISPATCH waits indefinitely.

Structure
REQ-031 Package reg_router_pkg SHALL hold typedef region_t {start, end, used}, the state enum router_state_e, and default width constants.
REQ-032 Sub-module reg_router_region_table SHALL hold the slot array, the allocation pointer, and combinational lowest-index match logic (hit, one-hot idx).

Verification
REQ-033 Register 100-200, 201-300, 301-400 -> rg_done with slots 0,1,2; rg_ready=0 after the third.
REQ-034 Write (100,10), (210,21) -> tgt_valid=001 with addr 100 data 10; then 010 with addr 210 data 21; each at cycle 2 after accept.
REQ-035 Write (500,50) -> err_valid pulse, err_addr=500, no tgt_valid.
REQ-036 Register 50-40 -> rg_err, table unchanged; fourth registration when full -> rg_err.
REQ-037 Overlap 0-100 (slot0) and 50-150 (slot1), write 75 -> slot 0; tgt_ready low for 5 cycles -> outputs held stable, then complete.
REQ-038 ROUTER_TIMEOUT_EN with tgt_ready stuck low -> err_valid after 16 DISPATCH cycles; rst asserted mid-DISPATCH -> tgt_valid=0 immediately and table empty.
